// File: rtl/fifo_wr_adapter.sv
// fifo_wr_adapter
//   Write-side adapter in front of an async FIFO. A 2-entry in-order skid
//   buffer takes beats from a valid/ready source. It drains them into the
//   FIFO with a push strobe that is gated combinationally by the FIFO's
//   (already wclk-registered) full flag. Everything runs in the wclk domain.
//
// Ports
//   wclk       in   write-domain clock
//   reset_w    in   asynchronous, active-high reset
//   src_valid  in   source beat valid
//   src_data   in   [DW-1:0] source beat data
//   src_ready  out  adapter can accept a beat (registered)
//   push       out  write strobe to the async FIFO
//   wdata      out  [DW-1:0] data to the async FIFO (head entry)
//   full       in   async FIFO full, synchronous to wclk
//   busy       out  skid buffer non-empty
//   push_cnt   out  [CNT_W-1:0] total pushes, wrapping
//   stall_cnt  out  [CNT_W-1:0] cycles stalled by full, saturating
module fifo_wr_adapter #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             wclk,
  input  logic             reset_w,
  input  logic             src_valid,
  input  logic [DW-1:0]    src_data,
  output logic             src_ready,
  output logic             push,
  output logic [DW-1:0]    wdata,
  input  logic             full,
  output logic             busy,
  output logic [CNT_W-1:0] push_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  // State encodes occupancy directly: EMPTY=0, ONE=1, TWO=2.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [DW-1:0]      head_q, head_d;
  logic [DW-1:0]      tail_q, tail_d;
  logic               rdy_q, rdy_d;
  logic [CNT_W-1:0]   push_cnt_q, push_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               occ_nz;
  logic               accept;

  // An illegal encoding is treated as empty, so it never pushes.
  assign occ_nz = (state_q == ONE) || (state_q == TWO);
  assign accept = src_valid && rdy_q;

  // Combinational in full so a toggling full takes effect the same cycle.
  assign push      = occ_nz && !full;
  // head_q only changes when a new head is loaded, so wdata holds its last
  // value while the buffer is empty.
  assign wdata     = head_q;
  assign src_ready = rdy_q;
  assign busy      = (state_q != EMPTY);
  assign push_cnt  = push_cnt_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = src_data;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({accept, push})
          2'b11:   head_d = src_data;      // pass-through, occupancy stays 1
          2'b10: begin
            tail_d  = src_data;
            state_d = TWO;
          end
          2'b01:   state_d = EMPTY;
          default: ;
        endcase
      end
      TWO: begin
        // src_ready is low here, but an accept with push still keeps order:
        // the tail shifts to head and the new beat fills the tail.
        if (push) begin
          head_d = tail_q;
          if (accept) tail_d = src_data;
          else        state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    rdy_d       = (state_d != TWO);
    push_cnt_d  = push ? push_cnt_q + CNT_W'(1) : push_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (occ_nz && full && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge wclk or posedge reset_w) begin
    if (reset_w) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      rdy_q       <= 1'b0;
      push_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      rdy_q       <= rdy_d;
      push_cnt_q  <= push_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // The FIFO must never see a push while it reports full.
  a_no_push_when_full: assert property (
    @(posedge wclk) disable iff (reset_w) !(push && full));

endmodule

// File: tb/tb_fifo_wr_adapter.sv
// Directed bench for fifo_wr_adapter. Two instances share one stimulus:
// u_dut at default CNT_W=16 and u_dut4 at CNT_W=4 for wrap/saturation.
module tb_fifo_wr_adapter;

  localparam int DW = 8;

  logic          wclk = 1'b0;
  logic          reset_w;
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          full;

  logic          src_ready, push, busy;
  logic [DW-1:0] wdata;
  logic [15:0]   push_cnt, stall_cnt;

  logic          src_ready4, push4, busy4;
  logic [DW-1:0] wdata4;
  logic [3:0]    push_cnt4, stall_cnt4;

  int n_chk = 0;
  int n_err = 0;

  always #5 wclk = ~wclk;

  fifo_wr_adapter #(.DW(DW), .CNT_W(16)) u_dut (
    .wclk(wclk), .reset_w(reset_w), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .push(push), .wdata(wdata), .full(full),
    .busy(busy), .push_cnt(push_cnt), .stall_cnt(stall_cnt));

  fifo_wr_adapter #(.DW(DW), .CNT_W(4)) u_dut4 (
    .wclk(wclk), .reset_w(reset_w), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready4), .push(push4), .wdata(wdata4), .full(full),
    .busy(busy4), .push_cnt(push_cnt4), .stall_cnt(stall_cnt4));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge, then sample/drive 1 time unit later.
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    reset_w   = 1'b1;
    src_valid = 1'b0;
    src_data  = '0;
    full      = 1'b0;

    // ---- reset state
    #3;
    chk("rst_ready", 32'(src_ready), 0);
    chk("rst_push",  32'(push), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_pcnt",  32'(push_cnt), 0);
    chk("rst_scnt",  32'(stall_cnt), 0);
    @(negedge wclk);
    @(negedge wclk);
    reset_w = 1'b0;
    tick();
    chk("ready_after_rst", 32'(src_ready), 1);

    // ---- single beat
    src_valid = 1'b1; src_data = 8'hA5;
    tick();
    src_valid = 1'b0;
    chk("sb_push",  32'(push), 1);
    chk("sb_wdata", 32'(wdata), 32'hA5);
    chk("sb_busy1", 32'(busy), 1);
    tick();
    chk("sb_pcnt",  32'(push_cnt), 1);
    chk("sb_busy0", 32'(busy), 0);
    chk("sb_push0", 32'(push), 0);
    chk("sb_hold",  32'(wdata), 32'hA5);

    // ---- back-pressure
    full = 1'b1; src_valid = 1'b1; src_data = 8'h01;
    tick();                                   // 0x01 accepted, occ 1
    chk("bp_rdy1", 32'(src_ready), 1);
    chk("bp_push_full", 32'(push), 0);
    src_data = 8'h02;
    tick();                                   // 0x02 accepted, occ 2, stall 1
    chk("bp_rdy0", 32'(src_ready), 0);
    chk("bp_stall1", 32'(stall_cnt), 1);
    src_data = 8'h03;
    tick();                                   // not accepted, stall 2
    chk("bp_stall2", 32'(stall_cnt), 2);
    tick();                                   // stall 3
    chk("bp_stall3", 32'(stall_cnt), 3);
    chk("bp_push0", 32'(push), 0);
    chk("bp_rdy0b", 32'(src_ready), 0);
    chk("bp_head", 32'(wdata), 32'h01);
    full = 1'b0;
    #1;
    chk("bp_push_same_cycle", 32'(push), 1);
    tick();                                   // pushes 0x01
    chk("bp_w02", 32'(wdata), 32'h02);
    chk("bp_p02", 32'(push), 1);
    chk("bp_rdy_back", 32'(src_ready), 1);
    tick();                                   // pushes 0x02, accepts 0x03
    src_valid = 1'b0;
    chk("bp_w03", 32'(wdata), 32'h03);
    chk("bp_p03", 32'(push), 1);
    tick();                                   // pushes 0x03
    chk("bp_pcnt", 32'(push_cnt), 4);
    chk("bp_scnt", 32'(stall_cnt), 3);
    chk("bp_busy", 32'(busy), 0);

    // ---- streaming 0x10..0x1F
    src_valid = 1'b1; src_data = 8'h10;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("st_push",  32'(push), 1);
      chk("st_wdata", 32'(wdata), 32'h10 + 32'(i));
      chk("st_ready", 32'(src_ready), 1);
      if (i == 12) chk("wrap4_pcnt", 32'(push_cnt4), 0);
      src_data = 8'h11 + 8'(i);
    end
    src_valid = 1'b0;
    tick();
    chk("st_pcnt",  32'(push_cnt), 20);
    chk("st_pcnt4", 32'(push_cnt4), 4);
    chk("st_busy",  32'(busy), 0);

    // ---- stall saturation (4-bit instance)
    full = 1'b1; src_valid = 1'b1; src_data = 8'h55;
    tick();
    src_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_scnt",  32'(stall_cnt), 23);
    chk("sat_scnt4", 32'(stall_cnt4), 15);
    chk("sat_busy",  32'(busy), 1);
    full = 1'b0;
    #1;
    chk("sat_w55", 32'(wdata), 32'h55);
    tick();
    chk("sat_pcnt4", 32'(push_cnt4), 5);

    // ---- reset mid-operation with occ 2
    full = 1'b1; src_valid = 1'b1; src_data = 8'h77;
    tick();
    src_data = 8'h88;
    tick();
    src_valid = 1'b0;
    chk("mr_rdy_pre", 32'(src_ready), 0);
    #2;
    reset_w = 1'b1;
    #1;
    chk("mr_push",  32'(push), 0);
    chk("mr_rdy",   32'(src_ready), 0);
    chk("mr_busy",  32'(busy), 0);
    chk("mr_pcnt",  32'(push_cnt), 0);
    chk("mr_scnt",  32'(stall_cnt), 0);
    chk("mr_wdata", 32'(wdata), 0);
    full = 1'b0;
    #1;
    chk("mr_push_nofull", 32'(push), 0);
    @(negedge wclk);
    reset_w = 1'b0;
    tick();
    chk("mr_rel_push", 32'(push), 0);
    chk("mr_rel_rdy",  32'(src_ready), 1);
    tick();
    chk("mr_rel_pcnt", 32'(push_cnt), 0);
    chk("mr_rel_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
